// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared processor definitions used by the write-back register file:
//   register indices, CCR bit positions, the default reset stack pointer,
//   and the CCR update operation decoded each cycle.
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CCR_W    = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned NUM_REGS = 4;

  // Register indices; R3 doubles as the stack pointer.
  localparam logic [1:0] R0     = 2'd0;
  localparam logic [1:0] R1     = 2'd1;
  localparam logic [1:0] R2     = 2'd2;
  localparam logic [1:0] R3     = 2'd3;
  localparam logic [1:0] SP_IDX = R3;

  // CCR bit positions.
  localparam int unsigned CCR_Z = 0;
  localparam int unsigned CCR_N = 1;
  localparam int unsigned CCR_C = 2;
  localparam int unsigned CCR_V = 3;

  localparam logic [DATA_W-1:0] RESET_SP_DEFAULT = 8'hFF;

  // What happens to CCR / shadow CCR this cycle.
  typedef enum logic [1:0] {
    CCR_HOLD,
    CCR_LOAD,
    CCR_SAVE,
    CCR_RESTORE
  } ccr_op_e;

  // Restore dominates save (a simultaneous request is a restore only);
  // save suppresses the normal flag load from write-back.
  function automatic ccr_op_e ccr_op(input logic valid,
                                     input logic save,
                                     input logic restore);
    ccr_op_e op;
    if (restore)    op = CCR_RESTORE;
    else if (save)  op = CCR_SAVE;
    else if (valid) op = CCR_LOAD;
    else            op = CCR_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/wb_regfile_bypass_mux.sv
// -----------------------------------------------------------------------------
// wb_bypass_mux
//   One decode-stage read port with write-through bypass from write-back.
//   Ports:
//     rd_addr_i  - register index being read
//     regs_i     - current registered contents of R0..R3
//     wr_en_i    - a qualified general register write is happening this cycle
//     wr_addr_i  - target of that write
//     wr_data_i  - data of that write
//     sp_upd_i   - a qualified (non-overridden) SP update is happening
//     sp_data_i  - new SP value of that update
//     rd_data_o  - bypassed read data
// -----------------------------------------------------------------------------
module wb_bypass_mux
  import wb_regfile_pkg::*;
(
  input  logic [1:0]                        rd_addr_i,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_i,
  input  logic                              wr_en_i,
  input  logic [1:0]                        wr_addr_i,
  input  logic [DATA_W-1:0]                 wr_data_i,
  input  logic                              sp_upd_i,
  input  logic [DATA_W-1:0]                 sp_data_i,
  output logic [DATA_W-1:0]                 rd_data_o
);

  // The general write is checked first so that a write to R3 wins over a
  // concurrent SP update, matching what the register will actually hold.
  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_o = wr_data_i;
    end else if (sp_upd_i && (rd_addr_i == SP_IDX)) begin
      rd_data_o = sp_data_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage register file: four 8-bit registers (R3 = SP), a 4-bit
//   CCR with a shadow copy for interrupt entry / RTI, and a 16-bit count of
//   retired (valid) write-back cycles.
//   Ports:
//     clk, reset         - clock; asynchronous active-low reset
//     wb_*               - MEM/WB register outputs; ignored while wb_valid=0
//     save_flags         - copy CCR into shadow CCR (interrupt entry)
//     restore_flags      - copy shadow CCR into CCR (RTI); dominates save
//     rd_addr_a/b        - decode-stage read addresses
//     rd_data_a/b        - read data with same-cycle write-through bypass
//     sp_out, ccr_out    - registered R3 and CCR (no bypass)
//     retired_count      - registered retire counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter logic [7:0] RESET_SP = RESET_SP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  wb_data,
  input  logic [1:0]  wb_dest_reg,
  input  logic        wb_write_enable,
  input  logic        wb_valid,
  input  logic [3:0]  wb_flags,
  input  logic        wb_update_sp,
  input  logic [7:0]  wb_new_sp,
  input  logic        save_flags,
  input  logic        restore_flags,
  input  logic [1:0]  rd_addr_a,
  input  logic [1:0]  rd_addr_b,
  output logic [7:0]  rd_data_a,
  output logic [7:0]  rd_data_b,
  output logic [7:0]  sp_out,
  output logic [3:0]  ccr_out,
  output logic [15:0] retired_count
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [CCR_W-1:0]                ccr_q, ccr_d;
  logic [CCR_W-1:0]                shadow_q, shadow_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic    wr_en;
  logic    sp_upd;
  ccr_op_e ccr_sel;

  // Qualified write-back actions; everything from wb_* is gated by wb_valid.
  assign wr_en   = wb_valid & wb_write_enable;
  assign sp_upd  = wb_valid & wb_update_sp & ~(wr_en & (wb_dest_reg == SP_IDX));
  assign ccr_sel = ccr_op(wb_valid, save_flags, restore_flags);

  always_comb begin
    regs_d = regs_q;
    if (sp_upd) begin
      regs_d[SP_IDX] = wb_new_sp;
    end
    if (wr_en) begin
      regs_d[wb_dest_reg] = wb_data;
    end
  end

  always_comb begin
    ccr_d    = ccr_q;
    shadow_d = shadow_q;
    unique case (ccr_sel)
      CCR_RESTORE: ccr_d    = shadow_q;
      CCR_SAVE:    shadow_d = ccr_q;
      CCR_LOAD:    ccr_d    = wb_flags;
      default:     ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wb_valid) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q[R0]     <= '0;
      regs_q[R1]     <= '0;
      regs_q[R2]     <= '0;
      regs_q[SP_IDX] <= RESET_SP;
      ccr_q          <= '0;
      shadow_q       <= '0;
      cnt_q          <= '0;
    end else begin
      regs_q   <= regs_d;
      ccr_q    <= ccr_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  wb_bypass_mux u_bypass_a (
    .rd_addr_i (rd_addr_a),
    .regs_i    (regs_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (wb_dest_reg),
    .wr_data_i (wb_data),
    .sp_upd_i  (sp_upd),
    .sp_data_i (wb_new_sp),
    .rd_data_o (rd_data_a)
  );

  wb_bypass_mux u_bypass_b (
    .rd_addr_i (rd_addr_b),
    .regs_i    (regs_q),
    .wr_en_i   (wr_en),
    .wr_addr_i (wb_dest_reg),
    .wr_data_i (wb_data),
    .sp_upd_i  (sp_upd),
    .sp_data_i (wb_new_sp),
    .rd_data_o (rd_data_b)
  );

  assign sp_out        = regs_q[SP_IDX];
  assign retired_count = cnt_q;

  always_comb begin
    ccr_out        = '0;
    ccr_out[CCR_Z] = ccr_q[CCR_Z];
    ccr_out[CCR_N] = ccr_q[CCR_N];
    ccr_out[CCR_C] = ccr_q[CCR_C];
    ccr_out[CCR_V] = ccr_q[CCR_V];
  end

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Directed stimulus for wb_regfile. Each stimulus cycle queues its expected
//   outputs (tagged with the cycle they are due); a monitor on the falling
//   edge pops due entries and compares them against the DUT.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  localparam int K_RDA = 0;
  localparam int K_RDB = 1;
  localparam int K_SP  = 2;
  localparam int K_CCR = 3;
  localparam int K_CNT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  wb_data = '0;
  logic [1:0]  wb_dest_reg = '0;
  logic        wb_write_enable = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_flags = '0;
  logic        wb_update_sp = 1'b0;
  logic [7:0]  wb_new_sp = '0;
  logic        save_flags = 1'b0;
  logic        restore_flags = 1'b0;
  logic [1:0]  rd_addr_a = '0;
  logic [1:0]  rd_addr_b = '0;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic [7:0]  sp_out;
  logic [3:0]  ccr_out;
  logic [15:0] retired_count;

  wb_regfile #(.RESET_SP(8'hFF)) dut (
    .clk             (clk),
    .reset           (reset),
    .wb_data         (wb_data),
    .wb_dest_reg     (wb_dest_reg),
    .wb_write_enable (wb_write_enable),
    .wb_valid        (wb_valid),
    .wb_flags        (wb_flags),
    .wb_update_sp    (wb_update_sp),
    .wb_new_sp       (wb_new_sp),
    .save_flags      (save_flags),
    .restore_flags   (restore_flags),
    .rd_addr_a       (rd_addr_a),
    .rd_addr_b       (rd_addr_b),
    .rd_data_a       (rd_data_a),
    .rd_data_b       (rd_data_b),
    .sp_out          (sp_out),
    .ccr_out         (ccr_out),
    .retired_count   (retired_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_at(input int dly, input int kind,
                           input logic [15:0] exp, input string name);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] dest,
                       input logic [7:0] data, input logic [3:0] flags,
                       input logic upd, input logic [7:0] nsp,
                       input logic sv, input logic rs,
                       input logic [1:0] ra, input logic [1:0] rb);
    wb_valid        = v;
    wb_write_enable = we;
    wb_dest_reg     = dest;
    wb_data         = data;
    wb_flags        = flags;
    wb_update_sp    = upd;
    wb_new_sp       = nsp;
    save_flags      = sv;
    restore_flags   = rs;
    rd_addr_a       = ra;
    rd_addr_b       = rb;
  endtask

  task automatic idle(input logic [1:0] ra, input logic [1:0] rb);
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, ra, rb);
  endtask

  // Monitor: compare every queued expectation that is due this cycle.
  always @(negedge clk) begin
    int i;
    logic [15:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due <= cyc) begin
        case (sb[i].kind)
          K_RDA:   act = {8'h00, rd_data_a};
          K_RDB:   act = {8'h00, rd_data_b};
          K_SP:    act = {8'h00, sp_out};
          K_CCR:   act = {12'h000, ccr_out};
          default: act = retired_count;
        endcase
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h (cycle %0d)",
                   sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    // Reset held: activity on every input must not disturb state.
    tick();
    drive(1'b1, 1'b1, 2'd0, 8'hAA, 4'hF, 1'b1, 8'h12, 1'b1, 1'b0, 2'd0, 2'd3);
    expect_at(1, K_SP,  16'h00FF, "rst_hold_sp");
    expect_at(1, K_CCR, 16'h0000, "rst_hold_ccr");
    expect_at(1, K_CNT, 16'h0000, "rst_hold_cnt");
    tick();
    idle(2'd0, 2'd3);
    expect_at(0, K_RDA, 16'h0000, "rst_r0");
    expect_at(0, K_RDB, 16'h00FF, "rst_r3");
    tick();

    // Release between edges; the next edge must already take effect.
    reset = 1'b1;
    // T1: write R1=5A, flags 0101
    drive(1'b1, 1'b1, 2'd1, 8'h5A, 4'b0101, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 2'd0);
    expect_at(0, K_RDA, 16'h005A, "t1_bypass_r1");
    expect_at(0, K_RDB, 16'h0000, "t1_r0");
    expect_at(1, K_CNT, 16'h0001, "t1_cnt");
    expect_at(1, K_CCR, 16'h0005, "t1_ccr");
    expect_at(1, K_SP,  16'h00FF, "t1_sp");
    tick();
    // T2: idle reads
    idle(2'd1, 2'd3);
    expect_at(0, K_RDA, 16'h005A, "t2_r1_reg");
    expect_at(0, K_RDB, 16'h00FF, "t2_r3_reg");
    tick();
    // T3: write R3=10 together with SP update FE -> write wins
    drive(1'b1, 1'b1, 2'd3, 8'h10, 4'b0101, 1'b1, 8'hFE, 1'b0, 1'b0, 2'd3, 2'd1);
    expect_at(0, K_RDA, 16'h0010, "t3_bypass_r3_write_wins");
    expect_at(0, K_RDB, 16'h005A, "t3_r1");
    expect_at(1, K_SP,  16'h0010, "t3_sp");
    expect_at(1, K_CNT, 16'h0002, "t3_cnt");
    tick();
    // T4: SP update only
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0101, 1'b1, 8'h80, 1'b0, 1'b0, 2'd3, 2'd2);
    expect_at(0, K_RDA, 16'h0080, "t4_bypass_sp");
    expect_at(0, K_RDB, 16'h0000, "t4_r2");
    expect_at(1, K_SP,  16'h0080, "t4_sp");
    expect_at(1, K_CNT, 16'h0003, "t4_cnt");
    tick();
    // T5: write R2 and SP update together
    drive(1'b1, 1'b1, 2'd2, 8'hC3, 4'b0101, 1'b1, 8'h7F, 1'b0, 1'b0, 2'd2, 2'd3);
    expect_at(0, K_RDA, 16'h00C3, "t5_bypass_r2");
    expect_at(0, K_RDB, 16'h007F, "t5_bypass_sp");
    expect_at(1, K_SP,  16'h007F, "t5_sp");
    expect_at(1, K_CNT, 16'h0004, "t5_cnt");
    tick();
    // T6: save with valid flags -> CCR must not load
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 2'd0);
    expect_at(1, K_CCR, 16'h0005, "t6_save_ccr_held");
    expect_at(1, K_CNT, 16'h0005, "t6_cnt");
    tick();
    // T7: normal flag load
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b1010, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);
    expect_at(1, K_CCR, 16'h000A, "t7_ccr_load");
    expect_at(1, K_CNT, 16'h0006, "t7_cnt");
    tick();
    // T8: restore beats valid flags
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd0);
    expect_at(1, K_CCR, 16'h0005, "t8_restore");
    expect_at(1, K_CNT, 16'h0007, "t8_cnt");
    tick();
    // T9: load 0011
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'b0011, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);
    expect_at(1, K_CCR, 16'h0003, "t9_ccr_load");
    expect_at(1, K_CNT, 16'h0008, "t9_cnt");
    tick();
    // T10: save+restore together is a restore only
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0, 2'd0);
    expect_at(1, K_CCR, 16'h0005, "t10_save_restore");
    tick();
    // T11: shadow must still hold 0101
    drive(1'b0, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd0);
    expect_at(1, K_CCR, 16'h0005, "t11_shadow_kept");
    expect_at(1, K_CNT, 16'h0008, "t11_cnt");
    tick();
    // T12: bubble with write/update requests must be ignored
    drive(1'b0, 1'b1, 2'd0, 8'hEE, 4'hF, 1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 2'd3);
    expect_at(0, K_RDA, 16'h0000, "t12_bubble_no_bypass_r0");
    expect_at(0, K_RDB, 16'h007F, "t12_bubble_no_bypass_sp");
    expect_at(1, K_SP,  16'h007F, "t12_sp");
    expect_at(1, K_CCR, 16'h0005, "t12_ccr");
    expect_at(1, K_CNT, 16'h0008, "t12_cnt");
    tick();
    // T13: write R0
    drive(1'b1, 1'b1, 2'd0, 8'h3C, 4'b0110, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd1);
    expect_at(0, K_RDA, 16'h003C, "t13_bypass_r0");
    expect_at(0, K_RDB, 16'h005A, "t13_r1");
    expect_at(1, K_CCR, 16'h0006, "t13_ccr");
    expect_at(1, K_CNT, 16'h0009, "t13_cnt");
    tick();
    // T14: registered R0 / R2
    idle(2'd0, 2'd2);
    expect_at(0, K_RDA, 16'h003C, "t14_r0_reg");
    expect_at(0, K_RDB, 16'h00C3, "t14_r2_reg");
    tick();

    // Bring the counter to FFFF with 65526 more valid cycles.
    drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);
    repeat (65526) tick();
    idle(2'd0, 2'd0);
    expect_at(0, K_CNT, 16'hFFFF, "cnt_ffff");
    expect_at(0, K_CCR, 16'h0000, "ccr_after_run");
    tick();
    drive(1'b1, 1'b1, 2'd0, 8'h99, 4'b1001, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 2'd0);
    expect_at(0, K_RDA, 16'h0099, "wrap_bypass_r0");
    expect_at(1, K_CNT, 16'h0000, "cnt_wrap");
    expect_at(1, K_CCR, 16'h0009, "wrap_ccr");
    tick();
    idle(2'd0, 2'd3);
    expect_at(0, K_RDA, 16'h0099, "pre_rst_r0");
    expect_at(0, K_SP,  16'h007F, "pre_rst_sp");
    expect_at(0, K_RDB, 16'h007F, "pre_rst_r3");
    tick();

    // Asynchronous reset between edges.
    #2;
    reset = 1'b0;
    expect_at(0, K_SP,  16'h00FF, "async_rst_sp");
    expect_at(0, K_CCR, 16'h0000, "async_rst_ccr");
    expect_at(0, K_CNT, 16'h0000, "async_rst_cnt");
    expect_at(0, K_RDA, 16'h0000, "async_rst_r0");
    expect_at(0, K_RDB, 16'h00FF, "async_rst_r3");
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter RESET_SP, default 8'hFF, meaning the stack-pointer (R3) value after reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports wb_data [7:0], wb_dest_reg [1:0], wb_write_enable, wb_valid, wb_flags [3:0], wb_update_sp, wb_new_sp [7:0], all inputs, fed from the MEM/WB register outputs.
REQ-005 SHALL have inputs save_flags and restore_flags, 1 bit each: interrupt-entry CCR save and RTI CCR restore.
REQ-006 SHALL have inputs rd_addr_a and rd_addr_b, 2 bits each: decode-stage read addresses.
REQ-007 SHALL have outputs rd_data_a and rd_data_b, 8 bits each: read data with write-through bypass.
REQ-008 SHALL have outputs sp_out [7:0] (current R3), ccr_out [3:0] (Z,N,C,V at bits 0..3) and retired_count [15:0].

Function
REQ-009 SHALL hold four 8-bit registers R0..R3, a 4-bit CCR, a 4-bit shadow CCR and a 16-bit retire counter.
REQ-010 SHALL write wb_data into R[wb_dest_reg] at the rising edge when wb_valid=1 and wb_write_enable=1; no write otherwise.
REQ-011 SHALL load wb_new_sp into R3 when wb_valid=1 and wb_update_sp=1, unless REQ-010 writes R3 in the same cycle; in that case the REQ-010 write wins.
REQ-012 SHALL load wb_flags into CCR when wb_valid=1, restore_flags=0 and save_flags=0.
REQ-013 SHALL copy CCR into the shadow CCR when save_flags=1, and SHALL leave CCR unchanged that cycle.
REQ-014 SHALL copy the shadow CCR into CCR when restore_flags=1, taking priority over REQ-012.
REQ-015 SHALL treat save_flags=1 with restore_flags=1 as a restore only; the shadow CCR keeps its value.
REQ-016 SHALL increment retired_count by 1 on every cycle with wb_valid=1, wrapping from 16'hFFFF to 16'h0000.
REQ-017 SHALL drive rd_data_x combinationally as R[rd_addr_x], with these same-cycle bypasses:
- wb_data, when a REQ-010 write targets rd_addr_x;
- otherwise wb_new_sp, when rd_addr_x=3 and REQ-011 is active.
REQ-018 SHALL drive sp_out and ccr_out from the registered state, with no bypass, giving 1-cycle latency from input to output.
REQ-019 SHALL ignore every wb_* input while wb_valid=0 (flushed bubble), including wb_write_enable and wb_update_sp.

Reset
REQ-020 SHALL reset asynchronously when reset=0: R0..R2=8'h00, R3=RESET_SP, CCR=4'h0, shadow CCR=4'h0, retired_count=16'h0000.
REQ-021 SHALL hold all state at its reset value while reset=0, regardless of wb_valid, save_flags or restore_flags.
REQ-022 SHALL resume normal operation on the first rising edge after reset deasserts; inputs present at that edge take effect.

Structure
REQ-023 SHALL take from the shared processor package:
- the register-index constants R0..R3 and SP_IDX=3;
- the CCR bit positions Z=0, N=1, C=2, V=3;
- the default reset SP value 8'hFF.
REQ-024 SHALL place the read-with-bypass logic in one sub-module, wb_bypass_mux, instantiated once per read port.
REQ-025 SHALL contain no other sub-modules, and the retire counter SHALL be a single 16-bit register.

Verification
REQ-026 After reset, a write of wb_dest_reg=1, wb_data=8'h5A with wb_valid=1 and wb_write_enable=1 SHALL return rd_data_a=8'h5A in the same cycle (rd_addr_a=1) and R1=8'h5A from the next cycle.
REQ-027 A cycle with wb_update_sp=1, wb_new_sp=8'hFE and a write of wb_dest_reg=3, wb_data=8'h10 SHALL give sp_out=8'h10 on the next cycle.
REQ-028 With CCR=4'b0101, asserting save_flags, then applying wb_flags=4'b1010, then asserting restore_flags SHALL give ccr_out=4'b0101 after the final cycle.
REQ-029 A cycle with wb_valid=0, wb_write_enable=1, wb_update_sp=1 SHALL leave R0..R3, CCR and retired_count unchanged.
REQ-030 With retired_count preloaded to 16'hFFFF through 65535 valid cycles, one more valid cycle SHALL give 16'h0000.
REQ-031 Asserting reset=0 mid-stream, between clock edges, SHALL immediately give sp_out=8'hFF, ccr_out=4'h0, retired_count=16'h0000, and SHALL give rd_data_a=8'h00 for rd_addr_a=0 once bypass inputs are idle.
